instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: owns the fetch PC, drives the word-aligned byte address to instruction memory and captures the returned word.
- Buffers fetched words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts PC redirects from execute (branch/jump) and stops fetching after an EBREAK.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset; must be word-aligned.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.
- EBREAK_WORD, 32'h0010_0073, encoding that halts fetch.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mem_read_idx  output  32  byte address to instruction memory; always equals fetch_pc
- mem_read_en  output  1  high in a cycle where the returned word is captured
- mem_read_data  input  32  instruction word; valid combinationally in the same cycle as mem_read_idx
- instr_valid  output  1  FIFO head is valid
- instr_data  output  32  FIFO head instruction word
- instr_pc  output  32  FIFO head PC
- instr_ready  input  1  decode accepts the head this cycle
- redirect_valid  input  1  one-cycle request to redirect fetch
- redirect_pc  input  32  redirect target byte address
- halted  output  1  EBREAK fetched; fetch stopped
- fault  output  1  misaligned redirect seen; sticky

Behaviour:
- Reset, asynchronous while rst_n=0:
  - fetch_pc=RESET_PC; FIFO empty; state=RUN.
  - instr_valid=0, halted=0, fault=0, mem_read_en=0 while in reset.
  - instr_data=0, instr_pc=0.
  - Reset mid-operation discards FIFO contents and any pending halt or fault.
- States are RUN, HALT and FAULT. halted=(state==HALT); fault=(state==FAULT).
- pop = instr_valid & instr_ready.
- push = (state==RUN) & ~redirect_valid & (count<FIFO_DEPTH | pop).
- mem_read_en = push. Memory latency is zero: the word on mem_read_data is captured at the same clock edge.
- On push, at the edge:
  - Enqueue {fetch_pc, mem_read_data}.
  - fetch_pc <= fetch_pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - If mem_read_data==EBREAK_WORD, the word is still enqueued, state <= HALT and fetch_pc is not incremented.
- Full with a pop in the same cycle: pop and push both occur; count is unchanged.
- Empty: instr_valid=0 and instr_data/instr_pc hold their last values. instr_ready is ignored.
- Head outputs come from FIFO storage and the registered count; instr_valid rises the cycle after the first push.
- HALT: no pushes; mem_read_idx holds the EBREAK address; already-buffered words still drain through pop.
- redirect_valid=1 (highest priority, beats push and pop):
  - At the edge the FIFO is flushed, even if instr_ready=1 (head not consumed), and no push occurs.
  - If redirect_pc[1:0]==0: fetch_pc <= redirect_pc; state <= RUN, from RUN or HALT.
  - If redirect_pc[1:0]!=0: state <= FAULT and fetch_pc is unchanged.
- FAULT: no pushes; FIFO empty; redirects ignored; exit only via rst_n.
- Counter widths are clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset release, instr_ready=1, memory words 0x00208093 at 0x0-0x18 and EBREAK at 0x1C -> mem_read_idx 0x0,0x4,…,0x1C; eight accepted instructions with pc 0x0…0x1C in order; halted=1 from the edge capturing 0x1C; mem_read_idx stays 0x1C.
- instr_ready=0 for 5 cycles after reset -> exactly 2 pushes (pc 0x0, 0x4), mem_read_en=0 afterwards; then ready=1 -> pc 0x0, 0x4, 0x8 with no skip or duplicate.
- FIFO full and ready=1 for one cycle -> pop of 0x0 and push of 0x8 at the same edge; count stays 2.
- redirect_valid with redirect_pc=0x40 while FIFO holds 2 entries and instr_ready=1 -> next cycle instr_valid=0, mem_read_idx=0x40; then instr_pc=0x40, then 0x44.
- In HALT, redirect to 0x100 -> halted=0; fetch resumes at 0x100. Separately, redirect_pc=0x102 -> fault=1, instr_valid=0, a later aligned redirect is ignored, and rst_n low clears fault.
- RESET_PC=0xFFFF_FFF8 -> fetched pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rst_n asserted mid-stream -> instr_valid drops immediately (asynchronously).

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads one word per cycle from a
// zero-latency instruction memory and queues {pc, word} pairs for decode.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FIFO_DEPTH  = 2,
    parameter logic [31:0] EBREAK_WORD = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_read_idx,
    output logic        mem_read_en,
    input  logic [31:0] mem_read_data,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault
);
    localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      buf_data [FIFO_DEPTH];
    logic [31:0]      buf_pc   [FIFO_DEPTH];
    logic [31:0]      head_data;
    logic [31:0]      head_pc;
    logic [31:0]      last_data;
    logic [31:0]      last_pc;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             is_ebreak;

    assign fifo_full   = (count == DEPTH_C);
    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;
    // rst_n gates push so no read is reported while the block is held in reset
    assign push        = rst_n & (state == ST_RUN) & ~redirect_valid & (~fifo_full | pop);
    assign is_ebreak   = (mem_read_data == EBREAK_WORD);

    assign mem_read_idx = fetch_pc;
    assign mem_read_en  = push;
    assign halted       = (state == ST_HALT);
    assign fault        = (state == ST_FAULT);

    assign head_data  = buf_data[rd_ptr];
    assign head_pc    = buf_pc[rd_ptr];
    // An empty buffer keeps presenting the last head it showed
    assign instr_data = instr_valid ? head_data : last_data;
    assign instr_pc   = instr_valid ? head_pc : last_pc;

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= mem_read_data;
            buf_pc[wr_ptr]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            fetch_pc  <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            last_data <= '0;
            last_pc   <= '0;
        end else begin
            if (instr_valid) begin
                last_data <= head_data;
                last_pc   <= head_pc;
            end
            if (redirect_valid && state != ST_FAULT) begin
                // Redirect wins over push and pop: the queued words are wrong-path
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                if (redirect_pc[1:0] == 2'b00) begin
                    fetch_pc <= redirect_pc;
                    state    <= ST_RUN;
                end else begin
                    state <= ST_FAULT;
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    if (is_ebreak) begin
                        state <= ST_HALT;
                    end else begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// checked against a queue-based fetch model.
module tb_instruction_fetch_unit;
    localparam logic [31:0] EBRK  = 32'h0010_0073;
    localparam int          DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, mem_read_en, instr_valid, instr_ready, redirect_valid, halted, fault;
    logic [31:0] mem_read_idx, mem_read_data, instr_data, instr_pc, redirect_pc;
    logic        rst2_n, mem_read_en2, instr_valid2, instr_ready2, redirect_valid2, halted2, fault2;
    logic [31:0] mem_read_idx2, mem_read_data2, instr_data2, instr_pc2, redirect_pc2;

    logic        fill_const = 1'b0;
    logic        ebrk_en = 1'b0;
    logic [31:0] ebrk_addr = 32'h0;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic fc,
                                             input logic ee, input logic [31:0] ea);
        if (ee && a == ea) return EBRK;
        if (fc) return 32'h0020_8093;
        return {a[23:0], 8'h13};
    endfunction

    assign mem_read_data  = mem_word(mem_read_idx, fill_const, ebrk_en, ebrk_addr);
    assign mem_read_data2 = mem_word(mem_read_idx2, 1'b0, 1'b0, 32'h0);

    instruction_fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .mem_read_idx(mem_read_idx), .mem_read_en(mem_read_en),
        .mem_read_data(mem_read_data), .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_pc(instr_pc), .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halted(halted), .fault(fault)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst_n(rst2_n), .mem_read_idx(mem_read_idx2), .mem_read_en(mem_read_en2),
        .mem_read_data(mem_read_data2), .instr_valid(instr_valid2), .instr_data(instr_data2),
        .instr_pc(instr_pc2), .instr_ready(instr_ready2), .redirect_valid(redirect_valid2),
        .redirect_pc(redirect_pc2), .halted(halted2), .fault(fault2)
    );

    // Reference model: a queue of {pc, word}, the next fetch address and a mode
    logic [31:0] mq_pc[$];
    logic [31:0] mq_dt[$];
    logic [31:0] m_pc, m_lpc, m_ldt;
    int          m_st;
    logic        e_valid, e_en, e_halt, e_fault;
    logic [31:0] e_pc, e_dt, e_idx;

    logic [31:0] acc_pc[$];
    logic [31:0] acc_dt[$];
    logic [31:0] idx_log[$];

    task automatic model_reset(input logic [31:0] rpc);
        mq_pc.delete();
        mq_dt.delete();
        m_pc  = rpc;
        m_lpc = 32'h0;
        m_ldt = 32'h0;
        m_st  = 0;
    endtask

    task automatic model_exp();
        e_valid = (mq_pc.size() != 0);
        if (e_valid) begin
            e_pc = mq_pc[0];
            e_dt = mq_dt[0];
        end else begin
            e_pc = m_lpc;
            e_dt = m_ldt;
        end
        e_idx   = m_pc;
        e_en    = (m_st == 0) && !redirect_valid && (mq_pc.size() < DEPTH || (e_valid && instr_ready));
        e_halt  = (m_st == 1);
        e_fault = (m_st == 2);
    endtask

    task automatic tick();
        logic        v, p, s;
        logic [31:0] w;
        #1;
        if (instr_valid && instr_ready && !redirect_valid) begin
            acc_pc.push_back(instr_pc);
            acc_dt.push_back(instr_data);
        end
        if (mem_read_en) idx_log.push_back(mem_read_idx);
        v = (mq_pc.size() != 0);
        if (v) begin
            m_lpc = mq_pc[0];
            m_ldt = mq_dt[0];
        end
        if (redirect_valid && m_st != 2) begin
            mq_pc.delete();
            mq_dt.delete();
            if (redirect_pc[1:0] == 2'b00) begin
                m_pc = redirect_pc;
                m_st = 0;
            end else begin
                m_st = 2;
            end
        end else begin
            p = v && instr_ready;
            s = (m_st == 0) && !redirect_valid && (mq_pc.size() < DEPTH || p);
            if (p) begin
                void'(mq_pc.pop_front());
                void'(mq_dt.pop_front());
            end
            if (s) begin
                w = mem_word(m_pc, fill_const, ebrk_en, ebrk_addr);
                mq_pc.push_back(m_pc);
                mq_dt.push_back(w);
                if (w == EBRK) m_st = 1;
                else m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset(32'h0);
        acc_pc.delete();
        acc_dt.delete();
        idx_log.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b want 0", fault); end
        checks++; if (mem_read_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b want 0", mem_read_en); end
        checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", instr_data); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", instr_pc); end
        checks++; if (mem_read_idx !== 32'h0) begin errors++; $display("FAIL rst_idx got %h want 0", mem_read_idx); end
        do_reset();
    endtask

    task automatic test_ebreak_stream();
        logic        cap;
        logic [31:0] got;
        fill_const = 1'b1;
        ebrk_en    = 1'b1;
        ebrk_addr  = 32'h1C;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            #1;
            cap = mem_read_en && (mem_read_idx == 32'h1C);
            tick();
            if (cap) begin
                checks++;
                if (halted !== 1'b1) begin errors++; $display("FAIL ebrk_halt_edge got %b want 1", halted); end
            end
        end
        checks++; if (acc_pc.size() != 8) begin errors++; $display("FAIL ebrk_count got %0d want 8", acc_pc.size()); end
        checks++; if (idx_log.size() != 8) begin errors++; $display("FAIL ebrk_reads got %0d want 8", idx_log.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < acc_pc.size()) ? acc_pc[i] : 32'hDEAD_BEEF;
            checks++; if (got !== 32'(4 * i)) begin errors++; $display("FAIL ebrk_pc[%0d] got %h want %h", i, got, 32'(4 * i)); end
            got = (i < idx_log.size()) ? idx_log[i] : 32'hDEAD_BEEF;
            checks++; if (got !== 32'(4 * i)) begin errors++; $display("FAIL ebrk_idx[%0d] got %h want %h", i, got, 32'(4 * i)); end
            got = (i < acc_dt.size()) ? acc_dt[i] : 32'hDEAD_BEEF;
            checks++; if (got !== ((i == 7) ? EBRK : 32'h0020_8093)) begin errors++; $display("FAIL ebrk_word[%0d] got %h", i, got); end
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ebrk_halted got %b want 1", halted); end
        checks++; if (mem_read_idx !== 32'h1C) begin errors++; $display("FAIL ebrk_idx_hold got %h want 1c", mem_read_idx); end
        checks++; if (mem_read_en !== 1'b0) begin errors++; $display("FAIL ebrk_en got %b want 0", mem_read_en); end
        fill_const = 1'b0;
        ebrk_en    = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (mem_read_en) n++;
            tick();
        end
        #1;
        checks++; if (n != 2) begin errors++; $display("FAIL bp_pushes got %0d want 2", n); end
        checks++; if (mem_read_en !== 1'b0) begin errors++; $display("FAIL bp_en_full got %b want 0", mem_read_en); end
        checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin errors++; $display("FAIL bp_head got %h/%b want 0/1", instr_pc, instr_valid); end
        instr_ready = 1'b1;
        #1;
        checks++; if (mem_read_en !== 1'b1 || mem_read_idx !== 32'h8) begin errors++; $display("FAIL full_pop_push got %b@%h want 1@8", mem_read_en, mem_read_idx); end
        tick();
        instr_ready = 1'b0;
        #1;
        checks++; if (instr_pc !== 32'h4 || instr_valid !== 1'b1) begin errors++; $display("FAIL full_head got %h/%b want 4/1", instr_pc, instr_valid); end
        checks++; if (mem_read_en !== 1'b0) begin errors++; $display("FAIL full_count got en %b want 0", mem_read_en); end
        instr_ready = 1'b1;
        tick();
        tick();
        checks++; if (acc_pc.size() != 3) begin errors++; $display("FAIL bp_acc_n got %0d want 3", acc_pc.size()); end
        if (acc_pc.size() == 3) begin
            checks++; if (acc_pc[0] !== 32'h0 || acc_pc[1] !== 32'h4 || acc_pc[2] !== 32'h8) begin
                errors++; $display("FAIL bp_order got %h %h %h want 0 4 8", acc_pc[0], acc_pc[1], acc_pc[2]);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(); tick(); tick();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        checks++; if (mem_read_en !== 1'b0) begin errors++; $display("FAIL redir_no_push got %b want 0", mem_read_en); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", instr_valid); end
        checks++; if (mem_read_idx !== 32'h40) begin errors++; $display("FAIL redir_idx got %h want 40", mem_read_idx); end
        checks++; if (acc_pc.size() != 0) begin errors++; $display("FAIL redir_no_pop got %0d want 0", acc_pc.size()); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin errors++; $display("FAIL redir_first got %b/%h want 1/40", instr_valid, instr_pc); end
        checks++; if (instr_data !== 32'h0000_4013) begin errors++; $display("FAIL redir_data got %h want 00004013", instr_data); end
        tick();
        checks++; if (instr_pc !== 32'h44) begin errors++; $display("FAIL redir_second got %h want 44", instr_pc); end
    endtask

    task automatic test_halt_redirect();
        ebrk_en   = 1'b1;
        ebrk_addr = 32'h8;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (halted !== 1'b1 || mem_read_idx !== 32'h8) begin errors++; $display("FAIL halt_state got %b@%h want 1@8", halted, mem_read_idx); end
        checks++; if (mem_read_en !== 1'b0) begin errors++; $display("FAIL halt_en got %b want 0", mem_read_en); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_exit got %b want 0", halted); end
        checks++; if (mem_read_idx !== 32'h100 || mem_read_en !== 1'b1) begin errors++; $display("FAIL halt_resume got %h/%b want 100/1", mem_read_idx, mem_read_en); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin errors++; $display("FAIL halt_head got %b/%h want 1/100", instr_valid, instr_pc); end
        ebrk_en = 1'b0;
    endtask

    task automatic test_fault();
        do_reset();
        instr_ready = 1'b1;
        tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (fault !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL fault_set got %b/%b want 1/0", fault, halted); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fault_empty got %b want 0", instr_valid); end
        checks++; if (mem_read_idx !== 32'h8) begin errors++; $display("FAIL fault_pc got %h want 8", mem_read_idx); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (fault !== 1'b1 || mem_read_idx !== 32'h8) begin errors++; $display("FAIL fault_sticky got %b@%h want 1@8", fault, mem_read_idx); end
        checks++; if (mem_read_en !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL fault_idle got %b/%b want 0/0", mem_read_en, instr_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %b want 0", fault); end
        do_reset();
    endtask

    task automatic test_random();
        int r;
        ebrk_en   = 1'b1;
        ebrk_addr = 32'h80;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            instr_ready    = ($urandom_range(0, 9) < 7);
            r              = int'($urandom_range(0, 99));
            redirect_valid = (r < 6);
            redirect_pc    = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
            if (r == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 39) == 0) ebrk_addr = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
            #1;
            model_exp();
            checks++; if (instr_valid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, instr_valid, e_valid); end
            checks++; if (instr_pc !== e_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, instr_pc, e_pc); end
            checks++; if (instr_data !== e_dt) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", i, instr_data, e_dt); end
            checks++; if (mem_read_idx !== e_idx) begin errors++; $display("FAIL rnd_idx cyc %0d got %h want %h", i, mem_read_idx, e_idx); end
            checks++; if (mem_read_en !== e_en) begin errors++; $display("FAIL rnd_en cyc %0d got %b want %b", i, mem_read_en, e_en); end
            checks++; if (halted !== e_halt) begin errors++; $display("FAIL rnd_halted cyc %0d got %b want %b", i, halted, e_halt); end
            checks++; if (fault !== e_fault) begin errors++; $display("FAIL rnd_fault cyc %0d got %b want %b", i, fault, e_fault); end
            tick();
            if (m_st == 2 && $urandom_range(0, 3) == 0) begin
                rst_n = 1'b0;
                #1;
                checks++; if (fault !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rnd_async_rst got %b/%b want 0/0", fault, instr_valid); end
                do_reset();
            end
        end
        ebrk_en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] acc2[$];
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        #1;
        checks++; if (mem_read_idx2 !== 32'hFFFF_FFF8 || instr_valid2 !== 1'b0) begin errors++; $display("FAIL wrap_rst got %h/%b want fffffff8/0", mem_read_idx2, instr_valid2); end
        @(negedge clk);
        rst2_n       = 1'b1;
        instr_ready2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (instr_valid2 && instr_ready2) acc2.push_back(instr_pc2);
            @(posedge clk);
        end
        checks++; if (acc2.size() < 3) begin errors++; $display("FAIL wrap_count got %0d want >=3", acc2.size()); end
        if (acc2.size() >= 3) begin
            checks++; if (acc2[0] !== 32'hFFFF_FFF8 || acc2[1] !== 32'hFFFF_FFFC || acc2[2] !== 32'h0) begin
                errors++; $display("FAIL wrap_pcs got %h %h %h want fffffff8 fffffffc 0", acc2[0], acc2[1], acc2[2]);
            end
        end
        #2;
        checks++; if (instr_valid2 !== 1'b1) begin errors++; $display("FAIL wrap_prevalid got %b want 1", instr_valid2); end
        rst2_n = 1'b0;
        #1;
        checks++; if (instr_valid2 !== 1'b0) begin errors++; $display("FAIL wrap_async_drop got %b want 0", instr_valid2); end
        checks++; if (instr_pc2 !== 32'h0 || mem_read_idx2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_rst_vals got %h/%h want 0/fffffff8", instr_pc2, mem_read_idx2); end
    endtask

    initial begin
        rst2_n          = 1'b0;
        instr_ready2    = 1'b0;
        redirect_valid2 = 1'b0;
        redirect_pc2    = 32'h0;
        test_reset();
        test_ebreak_stream();
        test_backpressure();
        test_redirect();
        test_halt_redirect();
        test_fault();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
